// File: rtl/control_path_mc_if.sv
// control_path_mc_if: bundle of ID-stage inputs, multi-cycle handshake and
// pipeline control outputs for control_path_mc.
//   slave  modport: the control block (consumes ID/handshake, drives controls)
//   master modport: the core/bench side (drives ID/handshake, observes controls)
// Ports carried:
//   id_*_i          decoded ID instruction fields and hazard qualifiers
//   branch_taken_i  ID comparator result
//   mc_done_i       multi-cycle unit result ready
//   *_ctrl_o        per-stage control bundles (zero when the stage is a bubble)
//   wb_rd_we_o/rd_o write-back port control
//   alu_fwd_*_o     EX operand selects (00 regfile, 01 WB, 10 MEM)
//   br_fwd_*_o      MEM result to ID comparator
//   mc_start_o      one-cycle multi-cycle start pulse
//   pc_en_o, if_id_en_o, if_id_flush_o, pc_next_sel_o  front-end control
//   stop_o          sticky halt
//   stall_cnt_o     saturating stall-cycle count
interface control_path_mc_if #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
);
  logic              id_valid_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [4:0]        id_rs1_i;
  logic [4:0]        id_rs2_i;
  logic [4:0]        id_rd_i;
  logic              id_rs1_use_i;
  logic              id_rs2_use_i;
  logic              id_rd_we_i;
  logic              id_load_i;
  logic              id_branch_i;
  logic              id_mc_i;
  logic              id_stop_i;
  logic              branch_taken_i;
  logic              mc_done_i;

  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CTRL_W-1:0] mem_ctrl_o;
  logic [CTRL_W-1:0] wb_ctrl_o;
  logic              wb_rd_we_o;
  logic [4:0]        wb_rd_o;
  logic [1:0]        alu_fwd_a_o;
  logic [1:0]        alu_fwd_b_o;
  logic              br_fwd_a_o;
  logic              br_fwd_b_o;
  logic              mc_start_o;
  logic              pc_en_o;
  logic              if_id_en_o;
  logic              if_id_flush_o;
  logic              pc_next_sel_o;
  logic              stop_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport slave (
    input  id_valid_i, id_ctrl_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_rs1_use_i, id_rs2_use_i, id_rd_we_i, id_load_i,
           id_branch_i, id_mc_i, id_stop_i, branch_taken_i, mc_done_i,
    output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, wb_rd_we_o, wb_rd_o,
           alu_fwd_a_o, alu_fwd_b_o, br_fwd_a_o, br_fwd_b_o, mc_start_o,
           pc_en_o, if_id_en_o, if_id_flush_o, pc_next_sel_o, stop_o,
           stall_cnt_o
  );

  modport master (
    output id_valid_i, id_ctrl_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_rs1_use_i, id_rs2_use_i, id_rd_we_i, id_load_i,
           id_branch_i, id_mc_i, id_stop_i, branch_taken_i, mc_done_i,
    input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, wb_rd_we_o, wb_rd_o,
           alu_fwd_a_o, alu_fwd_b_o, br_fwd_a_o, br_fwd_b_o, mc_start_o,
           pc_en_o, if_id_en_o, if_id_flush_o, pc_next_sel_o, stop_o,
           stall_cnt_o
  );
endinterface

// File: rtl/control_path_mc.sv
// control_path_mc: control path of the 5-stage RV32IM_Zbb pipeline.
// Carries an opaque control bundle through ID/EX, EX/MEM and MEM/WB with a
// valid bit per stage, produces ALU/branch forwarding selects, load-use and
// branch-operand stalls, taken-branch flush, a multi-cycle EX handshake that
// freezes the front end, a stop-drain mode and a saturating stall counter.
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous reset, ACTIVE-HIGH despite the name
//   bus    control_path_mc_if.slave (ID inputs, mc handshake, all controls)
module control_path_mc #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32,
  parameter int MC_EN  = 1
) (
  input logic              clk,
  input logic              rst_n,
  control_path_mc_if.slave bus
);

  // state | meaning
  // IDLE  | no multi-cycle op running; a valid mc op in EX pulses start
  // BUSY  | unit running; EX holds its op until mc_done_i
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;

  localparam logic MC_ON = (MC_EN != 0);

  mc_state_t state, state_nxt;

  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic              ex_rd_we, ex_load, ex_mc, ex_stop;

  logic              mem_valid;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [4:0]        mem_rd;
  logic              mem_rd_we, mem_load, mem_stop;

  logic              wb_valid;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [4:0]        wb_rd;
  logic              wb_rd_we, wb_stop;

  logic              stop_flag;
  logic [CNT_W-1:0]  stall_cnt;

  logic              ex_mc_op, mc_start, ex_hold;
  logic              ex_hit_id, mem_hit_id;
  logic              load_use, br_stall, hazard, drain;
  logic              front_en, id_take, stop;
  logic [1:0]        fwd_a, fwd_b;
  logic              br_fwd_a, br_fwd_b;

  // A producer stage matches a consumer register when it is a valid writer
  // of a non-zero rd equal to that register.
  function automatic logic wr_hit(input logic v, input logic we,
                                  input logic [4:0] rd, input logic [4:0] rs);
    return v && we && (rd != 5'd0) && (rd == rs);
  endfunction

  // ---------------- multi-cycle FSM ----------------
  assign ex_mc_op = MC_ON && ex_valid && ex_mc;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ex_mc_op) state_nxt = BUSY;
      BUSY:    if (bus.mc_done_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mc_done_i only matters in BUSY; in IDLE the start cycle always holds EX.
  always_comb begin
    mc_start = 1'b0;
    ex_hold  = 1'b0;
    case (state)
      IDLE: begin
        mc_start = ex_mc_op;
        ex_hold  = ex_mc_op;
      end
      BUSY:    ex_hold = !bus.mc_done_i;
      default: ;
    endcase
  end

  // ---------------- hazards ----------------
  always_comb begin
    ex_hit_id  = (bus.id_rs1_use_i && wr_hit(ex_valid, 1'b1, ex_rd, bus.id_rs1_i)) ||
                 (bus.id_rs2_use_i && wr_hit(ex_valid, 1'b1, ex_rd, bus.id_rs2_i));
    mem_hit_id = (bus.id_rs1_use_i && wr_hit(mem_valid, 1'b1, mem_rd, bus.id_rs1_i)) ||
                 (bus.id_rs2_use_i && wr_hit(mem_valid, 1'b1, mem_rd, bus.id_rs2_i));
  end

  assign load_use = bus.id_valid_i && ex_load && ex_hit_id;
  // A branch cannot take an EX result or a MEM load result, only a MEM ALU
  // result through the comparator bypass.
  assign br_stall = bus.id_valid_i && bus.id_branch_i &&
                    ((ex_rd_we && ex_hit_id) || (mem_load && mem_hit_id));
  assign hazard   = load_use || br_stall;

  assign stop  = stop_flag || (wb_valid && wb_stop);
  assign drain = stop_flag || (ex_valid && ex_stop) ||
                 (mem_valid && mem_stop) || (wb_valid && wb_stop);

  // Front end runs only out of reset with no freeze, drain or hazard.
  assign front_en = !rst_n && !ex_hold && !drain && !hazard;
  assign id_take  = bus.id_valid_i && !drain && !hazard;

  // ---------------- forwarding ----------------
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_valid) begin
      if (wr_hit(mem_valid, mem_rd_we, mem_rd, ex_rs1))     fwd_a = 2'b10;
      else if (wr_hit(wb_valid, wb_rd_we, wb_rd, ex_rs1))   fwd_a = 2'b01;
      if (wr_hit(mem_valid, mem_rd_we, mem_rd, ex_rs2))     fwd_b = 2'b10;
      else if (wr_hit(wb_valid, wb_rd_we, wb_rd, ex_rs2))   fwd_b = 2'b01;
    end
  end

  always_comb begin
    br_fwd_a = bus.id_valid_i && bus.id_branch_i && bus.id_rs1_use_i &&
               wr_hit(mem_valid, mem_rd_we && !mem_load, mem_rd, bus.id_rs1_i);
    br_fwd_b = bus.id_valid_i && bus.id_branch_i && bus.id_rs2_use_i &&
               wr_hit(mem_valid, mem_rd_we && !mem_load, mem_rd, bus.id_rs2_i);
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_rd_we  <= 1'b0;
      ex_load   <= 1'b0;
      ex_mc     <= 1'b0;
      ex_stop   <= 1'b0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_rd    <= '0;
      mem_rd_we <= 1'b0;
      mem_load  <= 1'b0;
      mem_stop  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_rd     <= '0;
      wb_rd_we  <= 1'b0;
      wb_stop   <= 1'b0;
      stop_flag <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!ex_hold) begin
        if (id_take) begin
          ex_valid <= 1'b1;
          ex_ctrl  <= bus.id_ctrl_i;
          ex_rs1   <= bus.id_rs1_i;
          ex_rs2   <= bus.id_rs2_i;
          ex_rd    <= bus.id_rd_i;
          ex_rd_we <= bus.id_rd_we_i;
          ex_load  <= bus.id_load_i;
          ex_mc    <= bus.id_mc_i && MC_ON;
          ex_stop  <= bus.id_stop_i;
        end else begin
          ex_valid <= 1'b0;
          ex_ctrl  <= '0;
          ex_rs1   <= '0;
          ex_rs2   <= '0;
          ex_rd    <= '0;
          ex_rd_we <= 1'b0;
          ex_load  <= 1'b0;
          ex_mc    <= 1'b0;
          ex_stop  <= 1'b0;
        end
      end

      // While EX holds, MEM takes bubbles so older ops keep draining.
      if (ex_hold) begin
        mem_valid <= 1'b0;
        mem_ctrl  <= '0;
        mem_rd    <= '0;
        mem_rd_we <= 1'b0;
        mem_load  <= 1'b0;
        mem_stop  <= 1'b0;
      end else begin
        mem_valid <= ex_valid;
        mem_ctrl  <= ex_ctrl;
        mem_rd    <= ex_rd;
        mem_rd_we <= ex_rd_we;
        mem_load  <= ex_load;
        mem_stop  <= ex_stop;
      end

      wb_valid <= mem_valid;
      wb_ctrl  <= mem_ctrl;
      wb_rd    <= mem_rd;
      wb_rd_we <= mem_rd_we;
      wb_stop  <= mem_stop;

      if (wb_valid && wb_stop) stop_flag <= 1'b1;

      if (!front_en && !stop && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // ---------------- outputs ----------------
  assign bus.ex_ctrl_o     = ex_ctrl;
  assign bus.mem_ctrl_o    = mem_ctrl;
  assign bus.wb_ctrl_o     = wb_ctrl;
  assign bus.wb_rd_we_o    = wb_valid && wb_rd_we;
  assign bus.wb_rd_o       = wb_rd;
  assign bus.alu_fwd_a_o   = fwd_a;
  assign bus.alu_fwd_b_o   = fwd_b;
  assign bus.br_fwd_a_o    = br_fwd_a;
  assign bus.br_fwd_b_o    = br_fwd_b;
  assign bus.mc_start_o    = mc_start;
  assign bus.pc_en_o       = front_en;
  assign bus.if_id_en_o    = front_en;
  assign bus.if_id_flush_o = front_en && bus.id_valid_i && bus.id_branch_i && bus.branch_taken_i;
  assign bus.pc_next_sel_o = front_en && bus.id_valid_i && bus.id_branch_i && bus.branch_taken_i;
  assign bus.stop_o        = stop;
  assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_control_path_mc.sv
module tb_control_path_mc;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  control_path_mc_if #(.CTRL_W(16), .CNT_W(32)) bus ();
  control_path_mc_if #(.CTRL_W(16), .CNT_W(4))  sat_bus ();

  control_path_mc #(.CTRL_W(16), .CNT_W(32), .MC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  control_path_mc #(.CTRL_W(16), .CNT_W(4), .MC_EN(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sat_bus)
  );

  assign sat_bus.id_valid_i     = bus.id_valid_i;
  assign sat_bus.id_ctrl_i      = bus.id_ctrl_i;
  assign sat_bus.id_rs1_i       = bus.id_rs1_i;
  assign sat_bus.id_rs2_i       = bus.id_rs2_i;
  assign sat_bus.id_rd_i        = bus.id_rd_i;
  assign sat_bus.id_rs1_use_i   = bus.id_rs1_use_i;
  assign sat_bus.id_rs2_use_i   = bus.id_rs2_use_i;
  assign sat_bus.id_rd_we_i     = bus.id_rd_we_i;
  assign sat_bus.id_load_i      = bus.id_load_i;
  assign sat_bus.id_branch_i    = bus.id_branch_i;
  assign sat_bus.id_mc_i        = bus.id_mc_i;
  assign sat_bus.id_stop_i      = bus.id_stop_i;
  assign sat_bus.branch_taken_i = bus.branch_taken_i;
  assign sat_bus.mc_done_i      = bus.mc_done_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic [15:0] ctrl, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic we,
                        input logic ld, input logic br, input logic mc,
                        input logic stp, input logic tk);
    bus.id_valid_i     = 1'b1;
    bus.id_ctrl_i      = ctrl;
    bus.id_rd_i        = rd;
    bus.id_rs1_i       = rs1;
    bus.id_rs2_i       = rs2;
    bus.id_rs1_use_i   = u1;
    bus.id_rs2_use_i   = u2;
    bus.id_rd_we_i     = we;
    bus.id_load_i      = ld;
    bus.id_branch_i    = br;
    bus.id_mc_i        = mc;
    bus.id_stop_i      = stp;
    bus.branch_taken_i = tk;
  endtask

  task automatic id_clear();
    bus.id_valid_i     = 1'b0;
    bus.id_ctrl_i      = '0;
    bus.id_rd_i        = '0;
    bus.id_rs1_i       = '0;
    bus.id_rs2_i       = '0;
    bus.id_rs1_use_i   = 1'b0;
    bus.id_rs2_use_i   = 1'b0;
    bus.id_rd_we_i     = 1'b0;
    bus.id_load_i      = 1'b0;
    bus.id_branch_i    = 1'b0;
    bus.id_mc_i        = 1'b0;
    bus.id_stop_i      = 1'b0;
    bus.branch_taken_i = 1'b0;
  endtask

  task automatic alu(input logic [15:0] ctrl, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    id_set(ctrl, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    id_clear();
    repeat (n) tick();
  endtask

  task automatic do_reset();
    id_clear();
    bus.mc_done_i = 1'b0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.mc_done_i = 1'b1;
    id_set(16'h0301, 5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++; if (bus.pc_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en: got %0b want 0", bus.pc_en_o); end
    n_checks++; if (bus.if_id_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_if_id_en: got %0b want 0", bus.if_id_en_o); end
    n_checks++; if ({bus.if_id_flush_o, bus.pc_next_sel_o} !== 2'b00) begin n_fail++; $display("FAIL reset_flush: got %0b want 00", {bus.if_id_flush_o, bus.pc_next_sel_o}); end
    n_checks++; if (bus.stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt_o); end
    n_checks++;
    if ({bus.ex_ctrl_o, bus.mem_ctrl_o, bus.wb_ctrl_o, bus.wb_rd_we_o, bus.wb_rd_o, bus.alu_fwd_a_o,
         bus.alu_fwd_b_o, bus.br_fwd_a_o, bus.br_fwd_b_o, bus.mc_start_o, bus.stop_o} !== 63'd0) begin
      n_fail++; $display("FAIL reset_other: got ex=%h mem=%h wb=%h mcs=%b stop=%b want all 0",
                         bus.ex_ctrl_o, bus.mem_ctrl_o, bus.wb_ctrl_o, bus.mc_start_o, bus.stop_o);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    alu(16'h0A01, 5'd5, 5'd1, 5'd2);
    tick();
    alu(16'h0A02, 5'd6, 5'd5, 5'd5);
    #1;
    n_checks++; if (bus.ex_ctrl_o !== 16'h0A01) begin n_fail++; $display("FAIL fwd_ex_ctrl: got %h want 0a01", bus.ex_ctrl_o); end
    n_checks++; if (bus.pc_en_o !== 1'b1) begin n_fail++; $display("FAIL fwd_no_stall: got %0b want 1", bus.pc_en_o); end
    tick();
    id_clear();
    #1;
    n_checks++; if ({bus.alu_fwd_a_o, bus.alu_fwd_b_o} !== 4'b1010) begin n_fail++; $display("FAIL fwd_mem: got %b want 1010", {bus.alu_fwd_a_o, bus.alu_fwd_b_o}); end
    tick();
    n_checks++; if ({bus.wb_ctrl_o, bus.wb_rd_we_o, bus.wb_rd_o} !== {16'h0A01, 1'b1, 5'd5}) begin n_fail++; $display("FAIL fwd_wb: got ctrl=%h we=%b rd=%0d want 0a01/1/5", bus.wb_ctrl_o, bus.wb_rd_we_o, bus.wb_rd_o); end
    drain(3);
    // WB feeds rs1, MEM feeds rs2
    alu(16'h0A03, 5'd5, 5'd1, 5'd2); tick();
    alu(16'h0A04, 5'd9, 5'd1, 5'd2); tick();
    alu(16'h0A05, 5'd6, 5'd5, 5'd9); tick();
    id_clear();
    #1;
    n_checks++; if ({bus.alu_fwd_a_o, bus.alu_fwd_b_o} !== 4'b0110) begin n_fail++; $display("FAIL fwd_wb_mem: got %b want 0110", {bus.alu_fwd_a_o, bus.alu_fwd_b_o}); end
    drain(3);
    alu(16'h0A06, 5'd0, 5'd1, 5'd2); tick();
    alu(16'h0A07, 5'd6, 5'd0, 5'd0); tick();
    id_clear();
    #1;
    n_checks++; if ({bus.alu_fwd_a_o, bus.alu_fwd_b_o} !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0: got %b want 0000", {bus.alu_fwd_a_o, bus.alu_fwd_b_o}); end
    drain(3);
    // both MEM and WB write x5: the younger MEM result wins
    alu(16'h0A08, 5'd5, 5'd1, 5'd2); tick();
    alu(16'h0A09, 5'd5, 5'd1, 5'd2); tick();
    alu(16'h0A0A, 5'd6, 5'd5, 5'd5); tick();
    id_clear();
    #1;
    n_checks++; if ({bus.alu_fwd_a_o, bus.alu_fwd_b_o} !== 4'b1010) begin n_fail++; $display("FAIL fwd_priority: got %b want 1010", {bus.alu_fwd_a_o, bus.alu_fwd_b_o}); end
  endtask

  task automatic test_load_use();
    do_reset();
    id_set(16'h0701, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.pc_en_o !== 1'b1) begin n_fail++; $display("FAIL lu_accept: got %0b want 1", bus.pc_en_o); end
    tick();
    alu(16'h0801, 5'd8, 5'd7, 5'd1);
    #1;
    n_checks++; if ({bus.pc_en_o, bus.if_id_en_o} !== 2'b00) begin n_fail++; $display("FAIL lu_stall: got %b want 00", {bus.pc_en_o, bus.if_id_en_o}); end
    tick();
    n_checks++; if (bus.ex_ctrl_o !== 16'h0000) begin n_fail++; $display("FAIL lu_bubble: got %h want 0000", bus.ex_ctrl_o); end
    n_checks++; if (bus.pc_en_o !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %0b want 1", bus.pc_en_o); end
    n_checks++; if (bus.mem_ctrl_o !== 16'h0701) begin n_fail++; $display("FAIL lu_mem: got %h want 0701", bus.mem_ctrl_o); end
    tick();
    id_clear();
    #1;
    n_checks++; if (bus.ex_ctrl_o !== 16'h0801) begin n_fail++; $display("FAIL lu_ex: got %h want 0801", bus.ex_ctrl_o); end
    n_checks++; if ({bus.alu_fwd_a_o, bus.alu_fwd_b_o} !== 4'b0100) begin n_fail++; $display("FAIL lu_fwd: got %b want 0100", {bus.alu_fwd_a_o, bus.alu_fwd_b_o}); end
    n_checks++; if (bus.stall_cnt_o !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", bus.stall_cnt_o); end
  endtask

  task automatic test_branch();
    do_reset();
    id_set(16'h0301, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    id_set(16'h0302, 5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if ({bus.pc_en_o, bus.if_id_flush_o, bus.pc_next_sel_o} !== 3'b000) begin n_fail++; $display("FAIL br_stall: got %b want 000", {bus.pc_en_o, bus.if_id_flush_o, bus.pc_next_sel_o}); end
    tick();
    n_checks++; if ({bus.br_fwd_a_o, bus.br_fwd_b_o} !== 2'b10) begin n_fail++; $display("FAIL br_fwd: got %b want 10", {bus.br_fwd_a_o, bus.br_fwd_b_o}); end
    n_checks++; if ({bus.pc_en_o, bus.if_id_flush_o, bus.pc_next_sel_o} !== 3'b111) begin n_fail++; $display("FAIL br_flush: got %b want 111", {bus.pc_en_o, bus.if_id_flush_o, bus.pc_next_sel_o}); end
    tick();
    id_clear();
    #1;
    n_checks++; if ({bus.if_id_flush_o, bus.ex_ctrl_o} !== {1'b0, 16'h0302}) begin n_fail++; $display("FAIL br_after: got flush=%b ex=%h want 0/0302", bus.if_id_flush_o, bus.ex_ctrl_o); end
    drain(3);
    // a load in MEM cannot feed the comparator
    id_set(16'h0303, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    id_clear();
    tick();
    id_set(16'h0304, 5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if ({bus.pc_en_o, bus.br_fwd_a_o, bus.if_id_flush_o} !== 3'b000) begin n_fail++; $display("FAIL br_mem_load: got %b want 000", {bus.pc_en_o, bus.br_fwd_a_o, bus.if_id_flush_o}); end
    tick();
    n_checks++; if ({bus.pc_en_o, bus.if_id_flush_o} !== 2'b11) begin n_fail++; $display("FAIL br_mem_load_go: got %b want 11", {bus.pc_en_o, bus.if_id_flush_o}); end
  endtask

  task automatic test_mc_divide();
    int frozen, starts, bub;
    do_reset();
    id_set(16'h0D10, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    alu(16'h0B11, 5'd11, 5'd1, 5'd2);
    #1;
    frozen = 0; starts = 0; bub = 0;
    // start cycle plus four BUSY cycles with done low
    for (int c = 0; c < 5; c++) begin
      if (bus.pc_en_o === 1'b0) frozen++;
      if (bus.mc_start_o === 1'b1) starts++;
      tick();
      if (bus.mem_ctrl_o === 16'h0000) bub++;
    end
    bus.mc_done_i = 1'b1;
    #1;
    n_checks++; if (starts !== 1) begin n_fail++; $display("FAIL mc_start_pulses: got %0d want 1", starts); end
    n_checks++; if (frozen !== 5) begin n_fail++; $display("FAIL mc_frozen: got %0d want 5", frozen); end
    n_checks++; if (bub !== 5) begin n_fail++; $display("FAIL mc_bubbles: got %0d want 5", bub); end
    n_checks++; if ({bus.pc_en_o, bus.mc_start_o, bus.ex_ctrl_o} !== {2'b10, 16'h0D10}) begin n_fail++; $display("FAIL mc_done_cycle: got pc_en=%b start=%b ex=%h want 1/0/0d10", bus.pc_en_o, bus.mc_start_o, bus.ex_ctrl_o); end
    tick();
    bus.mc_done_i = 1'b0;
    id_clear();
    #1;
    n_checks++; if ({bus.mem_ctrl_o, bus.ex_ctrl_o} !== {16'h0D10, 16'h0B11}) begin n_fail++; $display("FAIL mc_advance: got mem=%h ex=%h want 0d10/0b11", bus.mem_ctrl_o, bus.ex_ctrl_o); end
    n_checks++; if (bus.stall_cnt_o !== 32'd5) begin n_fail++; $display("FAIL mc_cnt: got %0d want 5", bus.stall_cnt_o); end
  endtask

  task automatic test_mc_reset();
    do_reset();
    id_set(16'h0D01, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_clear();
    bus.mc_done_i = 1'b1;
    #1;
    n_checks++; if ({bus.mc_start_o, bus.pc_en_o} !== 2'b10) begin n_fail++; $display("FAIL mcr_start: got %b want 10", {bus.mc_start_o, bus.pc_en_o}); end
    tick();
    bus.mc_done_i = 1'b0;
    #1;
    n_checks++; if ({bus.ex_ctrl_o, bus.mc_start_o} !== {16'h0D01, 1'b0}) begin n_fail++; $display("FAIL mcr_done_idle_ignored: got ex=%h start=%b want 0d01/0", bus.ex_ctrl_o, bus.mc_start_o); end
    tick();
    n_checks++; if (bus.stall_cnt_o !== 32'd2) begin n_fail++; $display("FAIL mcr_cnt: got %0d want 2", bus.stall_cnt_o); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.mc_start_o, bus.pc_en_o, bus.ex_ctrl_o, bus.mem_ctrl_o, bus.stall_cnt_o} !== 66'd0) begin
      n_fail++; $display("FAIL mcr_async: got start=%b pc_en=%b ex=%h mem=%h cnt=%0d want all 0",
                         bus.mc_start_o, bus.pc_en_o, bus.ex_ctrl_o, bus.mem_ctrl_o, bus.stall_cnt_o);
    end
    tick();
    rst_n = 1'b0;
    id_set(16'h0D02, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.pc_en_o !== 1'b1) begin n_fail++; $display("FAIL mcr_idle_pc_en: got %0b want 1", bus.pc_en_o); end
    tick();
    id_clear();
    #1;
    n_checks++; if ({bus.mc_start_o, bus.ex_ctrl_o} !== {1'b1, 16'h0D02}) begin n_fail++; $display("FAIL mcr_restart: got start=%b ex=%h want 1/0d02", bus.mc_start_o, bus.ex_ctrl_o); end
    tick();
    bus.mc_done_i = 1'b1;
    tick();
    bus.mc_done_i = 1'b0;
    #1;
    n_checks++; if (bus.mem_ctrl_o !== 16'h0D02) begin n_fail++; $display("FAIL mcr_finish: got %h want 0d02", bus.mem_ctrl_o); end
  endtask

  task automatic test_stop();
    int bad;
    do_reset();
    id_set(16'h0F00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.pc_en_o !== 1'b1) begin n_fail++; $display("FAIL stop_accept: got %0b want 1", bus.pc_en_o); end
    tick();
    alu(16'h0C01, 5'd12, 5'd1, 5'd2);
    #1;
    n_checks++; if ({bus.ex_ctrl_o, bus.pc_en_o, bus.if_id_en_o, bus.stop_o} !== {16'h0F00, 3'b000}) begin n_fail++; $display("FAIL stop_ex: got ex=%h pc_en=%b if_id=%b stop=%b want 0f00/0/0/0", bus.ex_ctrl_o, bus.pc_en_o, bus.if_id_en_o, bus.stop_o); end
    tick();
    alu(16'h0C02, 5'd13, 5'd1, 5'd2);
    #1;
    n_checks++; if ({bus.ex_ctrl_o, bus.mem_ctrl_o, bus.stop_o} !== {16'h0000, 16'h0F00, 1'b0}) begin n_fail++; $display("FAIL stop_mem: got ex=%h mem=%h stop=%b want 0000/0f00/0", bus.ex_ctrl_o, bus.mem_ctrl_o, bus.stop_o); end
    tick();
    alu(16'h0C03, 5'd14, 5'd1, 5'd2);
    #1;
    n_checks++; if ({bus.wb_ctrl_o, bus.stop_o} !== {16'h0F00, 1'b1}) begin n_fail++; $display("FAIL stop_wb: got wb=%h stop=%b want 0f00/1", bus.wb_ctrl_o, bus.stop_o); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.ex_ctrl_o !== 16'h0000 || bus.stop_o !== 1'b1 || bus.pc_en_o !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stop_sticky: got %0d bad cycles want 0", bad); end
    n_checks++; if (bus.stall_cnt_o !== 32'd2) begin n_fail++; $display("FAIL stop_cnt: got %0d want 2", bus.stall_cnt_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    // lw x7,0(x7) held in ID: stalls on every other cycle
    id_set(16'h0707, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    n_checks++; if ({bus.stall_cnt_o, sat_bus.stall_cnt_o} !== {32'd10, 4'd10}) begin n_fail++; $display("FAIL sat_mid: got %0d/%0d want 10/10", bus.stall_cnt_o, sat_bus.stall_cnt_o); end
    repeat (20) tick();
    n_checks++; if (bus.stall_cnt_o !== 32'd20) begin n_fail++; $display("FAIL sat_wide: got %0d want 20", bus.stall_cnt_o); end
    n_checks++; if (sat_bus.stall_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_narrow: got %0d want 15", sat_bus.stall_cnt_o); end
    id_clear();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    bus.mc_done_i = 1'b0;
    id_clear();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mc_divide();
    test_mc_reset();
    test_stop();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
